// File: rtl/bus_slave_mem.sv
// ---------------------------------------------------------------------------
// bus_slave_mem
//
// Memory-backed slave on the shared system bus. A request whose addr[15:12]
// matches BASE_ADDR is accepted, its fields are latched, WAIT_CYCLES wait
// states are inserted, then a single RAM access is made and ready pulses for
// one cycle. The slave then parks in HOLD until the master drops valid, so a
// valid that stays high cannot re-trigger the access.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-high reset
//   valid      in   1   master request strobe
//   mode       in   1   1 = write, 0 = read
//   addr       in  16   byte address (window in [15:12], offset in [MEM_AW-1:0])
//   wdata      in   8   write data
//   rdata      out  8   read data, updated only by read accesses
//   ready      out  1   one-cycle completion pulse
//   sel        out  1   high while a transaction is owned (WAIT/RESP/HOLD)
//   state_show out  2   FSM state encoding for debug
// ---------------------------------------------------------------------------
module bus_slave_mem #(
    parameter logic [3:0] BASE_ADDR   = 4'h1,
    parameter int         MEM_AW      = 12,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mode,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        sel,
    output logic [1:0]  state_show
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              mode_r;
    logic [MEM_AW-1:0] offset_r;
    logic [7:0]        wdata_r;
    logic [7:0]        rdata_r;
    logic              ready_r;
    logic              sel_r;

    // RAM is deliberately not reset; its contents are undefined until written.
    logic [7:0]        mem_r [0:(2**MEM_AW)-1];

    logic              hit_s;
    logic              access_s;
    logic              mem_we_s;

    // Request decode and the single access strobe of a transaction.
    always_comb begin
        hit_s    = valid && (addr[15:12] == BASE_ADDR);
        // Access only fires with valid still high: a dropped valid aborts.
        access_s = (state_r == ST_WAIT) && valid && (cnt_r == 4'd0);
        // Reset blocks the write so an in-flight write is dropped.
        mem_we_s = access_s && mode_r && !rst;
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[offset_r] <= wdata_r;
        end
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            mode_r   <= 1'b0;
            offset_r <= '0;
            wdata_r  <= 8'h00;
            rdata_r  <= 8'h00;
            ready_r  <= 1'b0;
            sel_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (hit_s) begin
                        // Only these latched copies are used from here on.
                        mode_r   <= mode;
                        offset_r <= addr[MEM_AW-1:0];
                        wdata_r  <= wdata;
                        cnt_r    <= 4'(WAIT_CYCLES);
                        sel_r    <= 1'b1;
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!valid) begin
                        sel_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        if (!mode_r) begin
                            rdata_r <= mem_r[offset_r];
                        end
                        ready_r <= 1'b1;
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ready_r <= 1'b0;
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    ready_r <= 1'b0;
                    if (!valid) begin
                        sel_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    ready_r <= 1'b0;
                    sel_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata      = rdata_r;
    assign ready      = ready_r;
    assign sel        = sel_r;
    assign state_show = state_r;

endmodule

// File: tb/tb_bus_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_mem
//
// Two slaves share one bus: slave A (window 1, 4 KiB, 2 wait states) and
// slave B (window 2, 16 bytes, no wait states). Expected latency and read
// data are pushed to a scoreboard queue when a request is driven and popped
// when ready is observed. A small memory model supplies read data.
// ---------------------------------------------------------------------------
module tb_bus_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        mode;
    logic [15:0] addr;
    logic [7:0]  wdata;

    logic [7:0]  rdata_a, rdata_b;
    logic        ready_a, ready_b;
    logic        sel_a, sel_b;
    logic [1:0]  st_a, st_b;

    always #5 clk = ~clk;

    bus_slave_mem #(.BASE_ADDR(4'h1), .MEM_AW(12), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .valid(valid), .mode(mode), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .sel(sel_a),
        .state_show(st_a)
    );

    bus_slave_mem #(.BASE_ADDR(4'h2), .MEM_AW(4), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .valid(valid), .mode(mode), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .sel(sel_b),
        .state_show(st_b)
    );

    typedef struct {
        int         lat;
        logic [7:0] rd;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model [logic [15:0]];
    logic [7:0] last_rd [2];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample point: 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model key: slave B only decodes addr[3:0], so its RAM aliases.
    function automatic logic [15:0] mkey(input logic [15:0] a);
        if (a[15:12] == 4'h2) return {a[15:12], 8'h00, a[3:0]};
        else                  return a;
    endfunction

    // Full transaction: request, wait for ready, hold valid, then release.
    task automatic run_txn(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           input int hold);
        int         s;
        int         n;
        logic       got;
        exp_t       e;
        s     = (a[15:12] == 4'h2) ? 1 : 0;
        e.lat = (s == 1) ? 2 : 4;
        e.rd  = wr ? last_rd[s] : model[mkey(a)];
        sb_q.push_back(e);
        mode  = wr;
        addr  = a;
        wdata = d;
        valid = 1'b1;
        n     = 0;
        got   = 1'b0;
        while (n < 20 && !got) begin
            cyc();
            n++;
            // Scramble the request after it is sampled; the slave must ignore it.
            if (n == 1) begin
                addr  = {a[15:12], ~a[11:0]};
                wdata = ~d;
                mode  = ~wr;
            end
            got = (s == 1) ? ready_b : ready_a;
        end
        e = sb_q.pop_front();
        check("latency", n, e.lat);
        check("rdata_at_ready", (s == 1) ? rdata_b : rdata_a, e.rd);
        if (wr) model[mkey(a)] = d;
        else    last_rd[s] = e.rd;
        for (int i = 0; i <= hold; i++) begin
            cyc();
            check("hold_ready", (s == 1) ? ready_b : ready_a, 1'b0);
            check("hold_state", (s == 1) ? st_b : st_a, 2'd3);
        end
        valid = 1'b0;
        cyc();
        check("idle_state", (s == 1) ? {sel_b, st_b} : {sel_a, st_a}, 3'b000);
        check("rdata_kept", (s == 1) ? rdata_b : rdata_a, last_rd[s]);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        mode  = 1'b0;
        addr  = 16'h0000;
        wdata = 8'h00;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (2) cyc();
        check("rst_a", {ready_a, rdata_a, sel_a, st_a}, 12'h000);
        check("rst_b", {ready_b, rdata_b, sel_b, st_b}, 12'h000);
        rst = 1'b0;
        cyc();

        // Basic write then read-back; rdata unchanged by the write.
        run_txn(1'b1, 16'h1234, 8'hAB, 0);
        run_txn(1'b0, 16'h1234, 8'h00, 0);

        // Miss: no slave responds.
        mode  = 1'b0;
        addr  = 16'h5678;
        valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("miss", {ready_a, sel_a, ready_b, sel_b, st_a, st_b}, 8'h00);
        end
        valid = 1'b0;
        cyc();

        // Aborted write must not reach the RAM.
        run_txn(1'b1, 16'h1010, 8'h11, 0);
        mode  = 1'b1;
        addr  = 16'h1010;
        wdata = 8'h55;
        valid = 1'b1;
        cyc();
        check("abort_wait", st_a, 2'd1);
        valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("abort_idle", {ready_a, sel_a, st_a}, 4'h0);
        end
        run_txn(1'b0, 16'h1010, 8'h00, 0);

        // Long held valid: one ready pulse, parked in HOLD.
        run_txn(1'b1, 16'h1300, 8'h77, 6);
        run_txn(1'b0, 16'h1300, 8'h00, 0);

        // Zero-wait slave, including an aliased read-back.
        run_txn(1'b1, 16'h2040, 8'h3C, 2);
        run_txn(1'b0, 16'h2040, 8'h00, 0);
        run_txn(1'b0, 16'h2FF0, 8'h00, 0);
        check("b_alias_a_untouched", sel_a, 1'b0);

        // Reset in the middle of a write's wait states drops the write.
        run_txn(1'b1, 16'h1020, 8'h22, 0);
        mode  = 1'b1;
        addr  = 16'h1020;
        wdata = 8'h99;
        valid = 1'b1;
        cyc();
        check("rst_mid_wait", st_a, 2'd1);
        rst = 1'b1;
        cyc();
        rst   = 1'b0;
        valid = 1'b0;
        check("rst_mid_a", {ready_a, rdata_a, sel_a, st_a}, 12'h000);
        check("rst_mid_b", rdata_b, 8'h00);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        cyc();
        run_txn(1'b0, 16'h1020, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
